// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter sharing one AXI block-transfer port between icache and dcache.
// One transaction at a time; a watchdog flags any transaction that stalls in GRANT.
module core_mem_arbiter #(
  parameter int ADDR_WIDTH       = 64,
  parameter int AXI_DATA_WIDTH   = 256,
  parameter int BLOCK_BYTES_LOG2 = 5,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_ic_req,
  input  logic [ADDR_WIDTH-1:0]     i_ic_addr,
  output logic                      o_ic_done,
  output logic [AXI_DATA_WIDTH-1:0] o_ic_block,
  input  logic                      i_dc_req,
  input  logic [ADDR_WIDTH-1:0]     i_dc_addr,
  input  logic                      i_dc_we,
  input  logic [AXI_DATA_WIDTH-1:0] i_dc_wblock,
  output logic                      o_dc_done,
  output logic [AXI_DATA_WIDTH-1:0] o_dc_block,
  output logic                      o_axi_req,
  output logic [ADDR_WIDTH-1:0]     o_axi_addr,
  output logic                      o_axi_we,
  output logic [AXI_DATA_WIDTH-1:0] o_axi_wblock,
  input  logic                      i_axi_done,
  input  logic [AXI_DATA_WIDTH-1:0] i_axi_rblock,
  output logic                      o_timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ~((ADDR_WIDTH'(1) << BLOCK_BYTES_LOG2) - ADDR_WIDTH'(1));

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RESP} state_t;
  typedef enum logic {GR_IC, GR_DC} grant_t;

  state_t                    state_q, state_d;
  grant_t                    last_q, last_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic                      we_q, we_d;
  logic [AXI_DATA_WIDTH-1:0] wblock_q, wblock_d;
  logic [AXI_DATA_WIDTH-1:0] ic_block_q, ic_block_d;
  logic [AXI_DATA_WIDTH-1:0] dc_block_q, dc_block_d;
  logic [WD_W-1:0]           wdog_q, wdog_d;
  logic                      tout_q, tout_d;
  logic [WD_W-1:0]           wdog_inc;
  logic                      pick_dc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      last_q     <= GR_DC;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wblock_q   <= '0;
      ic_block_q <= '0;
      dc_block_q <= '0;
      wdog_q     <= '0;
      tout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wblock_q   <= wblock_d;
      ic_block_q <= ic_block_d;
      dc_block_q <= dc_block_d;
      wdog_q     <= wdog_d;
      tout_q     <= tout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wblock_d   = wblock_q;
    ic_block_d = ic_block_q;
    dc_block_d = dc_block_q;
    wdog_d     = wdog_q;
    tout_d     = tout_q;
    wdog_inc   = wdog_q + 1'b1;
    // Dcache wins when it is the sole requester or icache had the last grant.
    pick_dc    = i_dc_req && (!i_ic_req || (last_q == GR_IC));
    unique case (state_q)
      S_IDLE: begin
        if (i_ic_req || i_dc_req) begin
          state_d = S_GRANT;
          if (pick_dc) begin
            last_d   = GR_DC;
            addr_d   = i_dc_addr & ALIGN_MASK;
            we_d     = i_dc_we;
            wblock_d = i_dc_wblock;
          end else begin
            last_d   = GR_IC;
            addr_d   = i_ic_addr & ALIGN_MASK;
            we_d     = 1'b0;
            wblock_d = '0;
          end
        end
      end
      S_GRANT: begin
        if (i_axi_done) begin
          state_d = S_RESP;
          wdog_d  = '0;
          if (last_q == GR_IC) ic_block_d = i_axi_rblock;
          else                 dc_block_d = i_axi_rblock;
        end else if (wdog_q != WD_MAX) begin
          wdog_d = wdog_inc;
          if (wdog_inc == WD_MAX) tout_d = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_axi_req     = (state_q == S_GRANT);
    o_ic_done     = (state_q == S_RESP) && (last_q == GR_IC);
    o_dc_done     = (state_q == S_RESP) && (last_q == GR_DC);
    o_axi_addr    = addr_q;
    o_axi_we      = we_q;
    o_axi_wblock  = wblock_q;
    o_ic_block    = ic_block_q;
    o_dc_block    = dc_block_q;
    o_timeout_err = tout_q;
  end

endmodule
